program_loader: RTL and testbench

- Supplies the instruction stream the CPU core fetches by PC. It is the writer end of the core's instruction-fetch interface.
- Accepts a program as a byte stream over a valid/ready handshake and stores it in internal program memory.
- Releases the core (cpu_run) once loading completes, then returns inst = mem[pc] combinationally each cycle.
- Sits between the host/testbench byte source and the core's inst input.

---
 rtl/program_loader.sv | 109 ++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: fills program memory over a valid/ready handshake,
// then releases the core and serves inst = mem[pc] combinationally.
module program_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [8:0]        load_len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [7:0]        inst,
    output logic              cpu_run,
    output logic              load_done,
    output logic              len_err,
    output logic [7:0]        checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [8:0] MAX_LEN = 9'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        latched_len;
    logic [8:0]        prog_len;
    logic [7:0]        mem [DEPTH];

    logic len_ok;
    logic start_ok;
    logic start_bad;
    logic xfer;
    logic last;

    assign len_ok    = (load_len != 9'd0) && (load_len <= MAX_LEN);
    assign start_ok  = load_start && len_ok && (state != LOAD);
    assign start_bad = load_start && !len_ok && (state != LOAD);
    assign xfer      = (state == LOAD) && in_valid;
    assign last      = (9'(wr_addr) == (latched_len - 9'd1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = LOAD;
            LOAD:    if (xfer && last) state_next = RUN;
            RUN:     if (start_ok) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_addr     <= '0;
            latched_len <= '0;
            prog_len    <= '0;
            checksum    <= '0;
            len_err     <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            load_done <= xfer && last;
            if (start_bad) begin
                len_err <= 1'b1;
            end
            if (start_ok) begin
                latched_len <= load_len;
                wr_addr     <= '0;
                checksum    <= '0;
            end
            if (xfer) begin
                checksum <= checksum ^ in_data;
                if (last) begin
                    prog_len <= latched_len;
                end else begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
            end
        end
    end

    // NOTE: program memory has no reset; only the write is suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst && xfer) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign in_ready = (state == LOAD);
    assign cpu_run  = (state == RUN);
    assign inst     = (cpu_run && (9'(pc) < prog_len)) ? mem[pc] : 8'h00;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven fetch checks plus
// hand-written load, reload, backpressure, illegal-length and reset sequences.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [8:0] load_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pc;
    logic [7:0] inst;
    logic       cpu_run;
    logic       load_done;
    logic       len_err;
    logic [7:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] exp_inst;
    } fetch_vec_t;

    fetch_vec_t vecs[$];

    program_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc         (pc),
        .inst       (inst),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .len_err    (len_err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            pc = vecs[i].pc;
            #1;
            check($sformatf("%s inst pc=%0d", tag, vecs[i].pc), 16'(inst), 16'(vecs[i].exp_inst));
        end
        vecs.delete();
    endtask

    task automatic start_load(input logic [8:0] len);
        load_start = 1'b1;
        load_len   = len;
        step();
        load_start = 1'b0;
    endtask

    logic [7:0] basic_bytes [4];
    logic [7:0] gap_bytes   [3];

    initial begin
        basic_bytes[0] = 8'h05; basic_bytes[1] = 8'h46;
        basic_bytes[2] = 8'h81; basic_bytes[3] = 8'hC4;
        gap_bytes[0]   = 8'hAA; gap_bytes[1]   = 8'h55; gap_bytes[2] = 8'hFF;

        rst = 1'b0; load_start = 1'b0; load_len = '0;
        in_data = '0; in_valid = 1'b0; pc = '0;
        #1;
        step();
        step();
        rst = 1'b1;
        step();

        // Reset then idle
        check("reset cpu_run", 16'(cpu_run), 16'd0);
        check("reset in_ready", 16'(in_ready), 16'd0);
        check("reset inst", 16'(inst), 16'h00);
        check("reset checksum", 16'(checksum), 16'h00);
        check("reset len_err", 16'(len_err), 16'd0);
        check("reset load_done", 16'(load_done), 16'd0);

        // Illegal lengths from IDLE
        start_load(9'd0);
        check("len0 len_err", 16'(len_err), 16'd1);
        check("len0 in_ready", 16'(in_ready), 16'd0);
        start_load(9'd257);
        check("len257 len_err", 16'(len_err), 16'd1);
        check("len257 in_ready", 16'(in_ready), 16'd0);
        check("len257 cpu_run", 16'(cpu_run), 16'd0);

        // Basic load of 4 bytes with in_valid held high
        start_load(9'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = basic_bytes[i];
            check($sformatf("basic in_ready b%0d", i), 16'(in_ready), 16'd1);
            check($sformatf("basic load_done b%0d", i), 16'(load_done), 16'd0);
            check($sformatf("basic cpu_run b%0d", i), 16'(cpu_run), 16'd0);
            step();
        end
        in_valid = 1'b0;
        check("basic load_done pulse", 16'(load_done), 16'd1);
        check("basic cpu_run", 16'(cpu_run), 16'd1);
        check("basic in_ready", 16'(in_ready), 16'd0);
        check("basic checksum", 16'(checksum), 16'h06);
        step();
        check("basic load_done drop", 16'(load_done), 16'd0);
        vecs.push_back('{8'd0, 8'h05});
        vecs.push_back('{8'd1, 8'h46});
        vecs.push_back('{8'd2, 8'h81});
        vecs.push_back('{8'd3, 8'hC4});
        vecs.push_back('{8'd4, 8'h00});
        vecs.push_back('{8'd255, 8'h00});
        run_fetch_table("basic");

        // Reload from RUN with 2 bytes
        pc = 8'd0;
        load_start = 1'b1;
        load_len   = 9'd2;
        #1;
        check("reload cpu_run before edge", 16'(cpu_run), 16'd1);
        step();
        load_start = 1'b0;
        check("reload cpu_run falls", 16'(cpu_run), 16'd0);
        check("reload in_ready", 16'(in_ready), 16'd1);
        check("reload checksum cleared", 16'(checksum), 16'h00);
        check("reload inst forced", 16'(inst), 16'h00);
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        check("reload inst mid-load", 16'(inst), 16'h00);
        in_data = 8'h20;
        step();
        in_valid = 1'b0;
        check("reload load_done", 16'(load_done), 16'd1);
        check("reload checksum", 16'(checksum), 16'h30);
        vecs.push_back('{8'd0, 8'h10});
        vecs.push_back('{8'd1, 8'h20});
        vecs.push_back('{8'd2, 8'h00});
        run_fetch_table("reload");

        // Backpressure gaps, load_start during LOAD, final byte with load_start
        start_load(9'd3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = gap_bytes[i];
            if (i == 2) begin
                load_start = 1'b1;
                load_len   = 9'd2;
            end
            step();
            in_valid   = 1'b0;
            load_start = 1'b0;
            if (i < 2) begin
                for (int g = 0; g < 5; g++) begin
                    if (g == 2) begin
                        load_start = 1'b1;
                        load_len   = 9'd1;
                    end
                    check($sformatf("gap load_done b%0d g%0d", i, g), 16'(load_done), 16'd0);
                    check($sformatf("gap in_ready b%0d g%0d", i, g), 16'(in_ready), 16'd1);
                    step();
                    load_start = 1'b0;
                end
            end
        end
        check("gap load_done", 16'(load_done), 16'd1);
        check("gap checksum", 16'(checksum), 16'h00);
        check("gap cpu_run", 16'(cpu_run), 16'd1);
        step();
        check("gap stays RUN", 16'(cpu_run), 16'd1);
        check("gap load_done drop", 16'(load_done), 16'd0);
        vecs.push_back('{8'd0, 8'hAA});
        vecs.push_back('{8'd1, 8'h55});
        vecs.push_back('{8'd2, 8'hFF});
        vecs.push_back('{8'd3, 8'h00});
        run_fetch_table("gap");

        // Reset mid-load
        start_load(9'd4);
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_data = 8'h02;
        step();
        rst     = 1'b0;
        in_data = 8'h03;
        step();
        rst      = 1'b1;
        in_valid = 1'b0;
        check("midrst cpu_run", 16'(cpu_run), 16'd0);
        check("midrst in_ready", 16'(in_ready), 16'd0);
        check("midrst checksum", 16'(checksum), 16'h00);
        check("midrst len_err", 16'(len_err), 16'd0);
        step();
        check("midrst stays idle", 16'(in_ready), 16'd0);
        start_load(9'd1);
        in_valid = 1'b1;
        in_data  = 8'h7E;
        step();
        in_valid = 1'b0;
        check("onebyte load_done", 16'(load_done), 16'd1);
        check("onebyte checksum", 16'(checksum), 16'h7E);
        vecs.push_back('{8'd0, 8'h7E});
        vecs.push_back('{8'd1, 8'h00});
        run_fetch_table("onebyte");

        // Illegal length from RUN, then maximum legal length
        start_load(9'd300);
        check("run illegal len_err", 16'(len_err), 16'd1);
        check("run illegal cpu_run", 16'(cpu_run), 16'd1);
        check("run illegal in_ready", 16'(in_ready), 16'd0);
        start_load(9'd256);
        check("len256 in_ready", 16'(in_ready), 16'd1);
        check("len256 cpu_run", 16'(cpu_run), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
